// File: rtl/alu_r32i_pkg.sv
// alu_r32i_pkg: operation codes and width constants shared by the ALU,
// its multiplier and the bench.
package alu_r32i_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned SHAMT_W    = 5;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_SLL    = 4'd2,
        OP_SLT    = 4'd3,
        OP_SLTU   = 4'd4,
        OP_XOR    = 4'd5,
        OP_SRL    = 4'd6,
        OP_SRA    = 4'd7,
        OP_OR     = 4'd8,
        OP_AND    = 4'd9,
        OP_CPY    = 4'd10,
        OP_MUL    = 4'd11,
        OP_MULH   = 4'd12,
        OP_MULHSU = 4'd13,
        OP_MULHU  = 4'd14,
        OP_RSVD   = 4'd15
    } alu_op_e;

    // Signedness select for the multiplier: bit 1 = A signed, bit 0 = B signed.
    localparam logic [1:0] MUL_UU = 2'b00;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_SS = 2'b11;

endpackage

// File: rtl/alu_r32i_mul.sv
// alu_r32i_mul: combinational signed/unsigned multiplier producing the full
// 2*DATA_W-bit product. Each operand is extended by one bit (sign or zero
// according to i_sign) so a single signed multiply covers all three cases.
module alu_r32i_mul
    import alu_r32i_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  logic [1:0]          i_sign,
    output logic [2*DATA_W-1:0] o_prod
);

    logic signed [DATA_W:0]     w_a_ext;
    logic signed [DATA_W:0]     w_b_ext;
    logic signed [2*DATA_W+1:0] w_prod;

    // Operand extension and the shared signed product.
    always_comb begin
        w_a_ext = {i_sign[1] & i_a[DATA_W-1], i_a};
        w_b_ext = {i_sign[0] & i_b[DATA_W-1], i_b};
        w_prod  = w_a_ext * w_b_ext;
        o_prod  = w_prod[2*DATA_W-1:0];
    end

endmodule

// File: rtl/alu_r32i.sv
// alu_r32i: registered integer ALU, one operation per cycle, 1-cycle latency.
// Build option: define ALU_R32I_MUL_EN to implement MUL/MULH/MULHSU/MULHU;
// without it no multiplier exists and those codes yield 0.
module alu_r32i
    import alu_r32i_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] A,
    input  logic signed [DATA_W-1:0] B,
    input  logic [3:0]               alucode,
    output logic signed [DATA_W-1:0] result
);

    alu_op_e              w_op;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [DATA_W-1:0]    w_a;
    logic [DATA_W-1:0]    w_b;
    logic [DATA_W-1:0]    w_next;
    logic [DATA_W-1:0]    r_result;

    assign w_op    = alu_op_e'(alucode);
    assign w_a     = A;
    assign w_b     = B;
    assign w_shamt = w_b[SHAMT_W-1:0];

`ifdef ALU_R32I_MUL_EN
    logic [1:0]          w_mul_sign;
    logic [2*DATA_W-1:0] w_prod;

    // Signedness select derived from the high-half multiply variant.
    always_comb begin
        w_mul_sign = MUL_SS;
        case (w_op)
            OP_MULHSU: w_mul_sign = MUL_SU;
            OP_MULHU:  w_mul_sign = MUL_UU;
            default:   w_mul_sign = MUL_SS;
        endcase
    end

    alu_r32i_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_sign (w_mul_sign),
        .o_prod (w_prod)
    );
`endif

    // Next-result selection from operands and operation code.
    always_comb begin
        w_next = '0;
        case (w_op)
            OP_ADD:  w_next = w_a + w_b;
            OP_SUB:  w_next = w_a - w_b;
            OP_SLL:  w_next = w_a << w_shamt;
            OP_SLT:  w_next = {{(DATA_W-1){1'b0}}, (A < B)};
            OP_SLTU: w_next = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
            OP_XOR:  w_next = w_a ^ w_b;
            OP_SRL:  w_next = w_a >> w_shamt;
            OP_SRA:  w_next = A >>> w_shamt;
            OP_OR:   w_next = w_a | w_b;
            OP_AND:  w_next = w_a & w_b;
            OP_CPY:  w_next = w_b;
`ifdef ALU_R32I_MUL_EN
            OP_MUL:    w_next = w_prod[DATA_W-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  w_next = w_prod[2*DATA_W-1:DATA_W];
`endif
            default: w_next = '0;
        endcase
    end

    // Result register; reset overrides any operation presented that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_result <= '0;
        end else begin
            r_result <= w_next;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_alu_r32i.sv
// tb_alu_r32i: directed self-checking bench for alu_r32i. Expected values
// are pushed to a scoreboard when each operation is driven and popped when
// the registered result is sampled one cycle later.
`timescale 1ns/1ps
module tb_alu_r32i;
    import alu_r32i_pkg::*;

    logic               clock;
    logic               reset;
    logic signed [31:0] A;
    logic signed [31:0] B;
    logic [3:0]         alucode;
    logic signed [31:0] result;

    int unsigned tests;
    int unsigned fails;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    alu_r32i #(
        .DATA_W (32)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .alucode (alucode),
        .result  (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one operation on the falling edge, then check it after the
    // following rising edge.
    task automatic step(input logic rst, input alu_op_e op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        @(negedge clock);
        reset   = rst;
        A       = a;
        B       = b;
        alucode = op;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (result === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", t, result, e);
        end
    endtask

    // Change inputs mid-cycle and confirm the registered result is unchanged.
    task automatic hold_check(input logic [31:0] exp, input string tag);
        @(negedge clock);
        A       = 32'h1234_5678;
        B       = 32'h0000_0011;
        alucode = OP_XOR;
        #2;
        tests++;
        assert (result === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, result, exp);
        end
    endtask

    localparam logic [31:0] NEG1 = 32'hFFFF_FFFF;

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        A       = '0;
        B       = '0;
        alucode = '0;

        // Reset state with a live operation present.
        step(1'b1, OP_ADD, 32'd9, 32'd4, 32'd0, "reset_state");

        // Add/subtract with wrap.
        step(1'b0, OP_ADD, 32'd9, 32'd4, 32'd13, "add");
        hold_check(32'd13, "no_comb_path");
        step(1'b0, OP_SUB, 32'd9, 32'd10, NEG1, "sub_neg");
        step(1'b0, OP_SUB, -32'sd78, -32'sd901, 32'd823, "sub_negops");
        step(1'b0, OP_ADD, NEG1, 32'd1, 32'd0, "add_wrap");

        // Compares.
        step(1'b0, OP_SLT,  32'd9,  32'd4,  32'd0, "slt_0");
        step(1'b0, OP_SLT,  32'd2,  32'd4,  32'd1, "slt_1");
        step(1'b0, OP_SLT,  -32'sd2, 32'd4, 32'd1, "slt_neg");
        step(1'b0, OP_SLTU, -32'sd2, 32'd4, 32'd0, "sltu_0");
        step(1'b0, OP_SLTU, -32'sd2, NEG1,  32'd1, "sltu_1");

        // Logic and shifts.
        step(1'b0, OP_AND, 32'd9, 32'd5, 32'd1,  "and");
        step(1'b0, OP_OR,  32'd9, 32'd5, 32'd13, "or");
        step(1'b0, OP_XOR, 32'd9, 32'd5, 32'd12, "xor");
        step(1'b0, OP_SLL, 32'd9, 32'd1, 32'd18, "sll");
        step(1'b0, OP_SRL, 32'd9, 32'd3, 32'd1,  "srl");
        step(1'b0, OP_SRA, 32'd9, 32'd3, 32'd1,  "sra_pos");
        step(1'b0, OP_SRA, -32'sd9, 32'd3, 32'hFFFF_FFFE, "sra_neg");
        step(1'b0, OP_SRL, -32'sd9, 32'd3, 32'h1FFF_FFFE, "srl_neg");
        step(1'b0, OP_SRA, -32'sd9, 32'd35, 32'hFFFF_FFFE, "sra_b35");
        step(1'b0, OP_SRL, -32'sd9, 32'd35, 32'h1FFF_FFFE, "srl_b35");
        step(1'b0, OP_SLL, 32'd9, 32'd33, 32'd18, "sll_b33");
        step(1'b0, OP_SLL, 32'd1, 32'd31, 32'h8000_0000, "sll_31");

        // Copy and reserved.
        step(1'b0, OP_CPY,  -32'sd9, 32'd3, 32'd3, "cpy");
        step(1'b0, OP_RSVD, -32'sd9, 32'd3, 32'd0, "reserved");

        // Multiplies: implemented only with the build option.
`ifdef ALU_R32I_MUL_EN
        step(1'b0, OP_MUL,    32'd2, 32'd4,  32'd8,          "mul");
        step(1'b0, OP_MUL,    32'd2, -32'sd4, 32'hFFFF_FFF8, "mul_neg");
        step(1'b0, OP_MULH,   32'd2, -32'sd4, NEG1,          "mulh");
        step(1'b0, OP_MULHU,  32'd2, -32'sd4, 32'd1,         "mulhu");
        step(1'b0, OP_MULHSU, 32'd2, -32'sd4, 32'd1,         "mulhsu");
        step(1'b0, OP_MULHSU, -32'sd2, 32'd4, NEG1,          "mulhsu_nega");
`else
        step(1'b0, OP_MUL,    32'd2, 32'd4,  32'd0, "mul_off");
        step(1'b0, OP_MUL,    32'd2, -32'sd4, 32'd0, "mul_neg_off");
        step(1'b0, OP_MULH,   32'd2, -32'sd4, 32'd0, "mulh_off");
        step(1'b0, OP_MULHU,  32'd2, -32'sd4, 32'd0, "mulhu_off");
        step(1'b0, OP_MULHSU, 32'd2, -32'sd4, 32'd0, "mulhsu_off");
`endif

        // Reset priority over a held operation, then recovery.
        step(1'b0, OP_ADD, 32'd9, 32'd4, 32'd13, "pre_reset");
        step(1'b1, OP_ADD, 32'd9, 32'd4, 32'd0,  "reset_priority");
        step(1'b0, OP_ADD, 32'd9, 32'd4, 32'd13, "post_reset");
        step(1'b0, OP_SUB, 32'd9, 32'd4, 32'd5,  "back_to_back");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
